// File: rtl/jstepper_pkg.sv
// Shared encodings for the jcscpu step sequencer: phase and state
// enumerations and the step counter width.
package jstepper_pkg;

    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        PH_P0 = 2'd0,
        PH_P1 = 2'd1,
        PH_P2 = 2'd2,
        PH_P3 = 2'd3
    } phase_t;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

endpackage

// File: rtl/jstepper_jclkphase.sv
// Four-phase counter inside one instruction step. Produces the registered
// enable/set strobes and a flag marking the step boundary (P3).
module jclkphase
    import jstepper_pkg::*;
(
    input  logic       wclk,
    input  logic       wrst_n,
    input  logic       clr,       // force P0 at the next edge
    input  logic       adv,       // step to the next phase (P3 wraps to P0)
    input  logic       run_next,  // sequencer will be in RUN after this edge
    output logic [1:0] phase,
    output logic       p3,
    output logic       wclke,
    output logic       wclks
);

    phase_t phase_q;
    phase_t phase_d;

    // Next phase: clear wins over advance, otherwise hold.
    always_comb begin
        // NOTE: default assigned first so every path drives phase_d and no latch is inferred.
        phase_d = phase_q;
        if (clr) begin
            phase_d = PH_P0;
        end else if (adv) begin
            phase_d = phase_t'(phase_q + 2'd1);
        end
    end

    // Phase register plus strobes decoded from the upcoming phase, so the
    // strobes are flop outputs that line up with the phase they describe.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            phase_q <= PH_P0;
            wclke   <= 1'b0;
            wclks   <= 1'b0;
        end else begin
            // NOTE: non-blocking so all flops sample pre-edge values together.
            phase_q <= phase_d;
            wclke   <= run_next && (phase_d != PH_P3);
            wclks   <= run_next && (phase_d == PH_P1);
        end
    end

    assign phase = phase_q;
    assign p3    = (phase_q == PH_P3);

endmodule

// File: rtl/jstepper.sv
// Control-phase sequencer: splits each instruction into NSTEPS steps of four
// clock cycles and emits a one-hot step vector plus enable/set strobes.
module jstepper
    import jstepper_pkg::*;
#(
    parameter int NSTEPS = 6
) (
    input  logic              wclk,
    input  logic              wrst_n,
    input  logic              wrun,
    input  logic              wrestart,
    output logic [NSTEPS-1:0] bstep,
    output logic              wclke,
    output logic              wclks,
    output logic              wlast,
    output logic              wbusy
);

    localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(NSTEPS - 1);

    state_t            state_q, state_d;
    logic [STEP_W-1:0] step_q, step_d;
    logic              ph_clr, ph_adv;
    logic              p3;
    logic [1:0]        phase;
    logic              run_next;
    logic              wlast_d;
    logic [NSTEPS-1:0] bstep_d;

    jclkphase u_phase (
        .wclk     (wclk),
        .wrst_n   (wrst_n),
        .clr      (ph_clr),
        .adv      (ph_adv),
        .run_next (run_next),
        .phase    (phase),
        .p3       (p3),
        .wclke    (wclke),
        .wclks    (wclks)
    );

    // Next state / step and phase-counter control. Restart beats everything;
    // wrun is only looked at in IDLE or at the last step boundary.
    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        ph_clr  = 1'b0;
        ph_adv  = 1'b0;
        if (wrestart) begin
            state_d = ST_IDLE;
            step_d  = '0;
            ph_clr  = 1'b1;
        end else if (state_q == ST_IDLE) begin
            ph_clr = 1'b1;
            if (wrun) begin
                state_d = ST_RUN;
                step_d  = '0;
            end
        end else if (!p3) begin
            ph_adv = 1'b1;
        end else if (step_q != LAST_STEP) begin
            step_d = step_q + 1'b1;
            ph_adv = 1'b1;
        end else if (wrun) begin
            step_d = '0;
            ph_adv = 1'b1;
        end else begin
            state_d = ST_IDLE;
            step_d  = '0;
            ph_clr  = 1'b1;
        end
    end

    assign run_next = (state_d == ST_RUN);
    // Upcoming phase is P3 only when advancing out of P2.
    assign wlast_d  = run_next && (step_d == LAST_STEP) && ph_adv && (phase == PH_P2);

    // One-hot decode of the upcoming step, zero when heading to IDLE.
    always_comb begin
        bstep_d = '0;
        for (int i = 0; i < NSTEPS; i++) begin
            bstep_d[i] = run_next && (step_d == STEP_W'(i));
        end
    end

    // State, step and registered step-related outputs.
    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state_q <= ST_IDLE;
            step_q  <= '0;
            bstep   <= '0;
            wlast   <= 1'b0;
        end else begin
            state_q <= state_d;
            step_q  <= step_d;
            bstep   <= bstep_d;
            wlast   <= wlast_d;
        end
    end

    assign wbusy = (state_q == ST_RUN);

endmodule
